// File: rtl/fifo_pkg.sv
// Shared types and defaults for the write-side FIFO blocks.
package fifo_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned DATA_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority pick: first set req bit searching upward from rr_ptr, wrapping.
module rr_pick #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic               valid
);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        valid = found;
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Round-robin write-port arbiter: grants one requester a burst of up to MAX_BURST
// FIFO writes, pausing in HOLD while the FIFO reports full.
module wr_port_arbiter
    import fifo_pkg::*;
#(
    parameter  int unsigned NUM_REQ   = NUM_REQ_DEF,
    parameter  int unsigned DATA_W    = DATA_W_DEF,
    parameter  int unsigned MAX_BURST = 4,
    localparam int unsigned PTR_W     = $clog2(NUM_REQ),
    localparam int unsigned CNT_W     = $clog2(MAX_BURST) + 1
) (
    input  logic                      wclk,
    input  logic                      wrst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata_in,
    input  logic                      full,
    output logic                      w_en,
    output logic [DATA_W-1:0]         wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    output logic [PTR_W-1:0]          owner,
    output logic                      stalled
);

    arb_state_t         state, state_n;
    logic [NUM_REQ-1:0] gnt_n;
    logic [PTR_W-1:0]   owner_n, rr_ptr, rr_ptr_n, pick_idx;
    logic [CNT_W-1:0]   burst_cnt, burst_cnt_n;
    logic [NUM_REQ-1:0] pick_oh;
    logic               pick_vld;
    logic               rel;

    logic [NUM_REQ-1:0][DATA_W-1:0] words;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .pick   (pick_oh),
        .valid  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_oh[PTR_W'(i)]) pick_idx = PTR_W'(i);
        end
    end

    // Write path is combinational so the owner's word lands in the same cycle; reset gates it off.
    assign words   = wdata_in;
    assign w_en    = wrst_n && (state == GRANT) && req[owner] && !full;
    assign wdata   = words[owner];
    assign ack     = w_en ? (NUM_REQ'(1) << owner) : '0;
    assign stalled = (state == HOLD);

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            owner     <= owner_n;
            rr_ptr    <= rr_ptr_n;
            burst_cnt <= burst_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        owner_n     = owner;
        rr_ptr_n    = rr_ptr;
        burst_cnt_n = burst_cnt;
        rel         = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_n       = pick_oh;
                    owner_n     = pick_idx;
                    burst_cnt_n = '0;
                    state_n     = GRANT;
                end
            end
            GRANT: begin
                if (!req[owner]) begin
                    rel = 1'b1;
                end else if (full) begin
                    state_n = HOLD;
                end else begin
                    burst_cnt_n = burst_cnt + CNT_W'(1);
                    if (burst_cnt == CNT_W'(MAX_BURST - 1)) rel = 1'b1;
                end
            end
            HOLD: begin
                if (!req[owner])  rel     = 1'b1;
                else if (!full)   state_n = GRANT;
            end
            default: state_n = IDLE;
        endcase
        // Releasing requester drops to lowest priority for the next arbitration.
        if (rel) begin
            state_n  = IDLE;
            gnt_n    = '0;
            owner_n  = '0;
            rr_ptr_n = PTR_W'((32'(owner) + 1) % NUM_REQ);
        end
    end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Bench for wr_port_arbiter: directed reset/round-robin run, then random traffic vs a reference model.
module tb_wr_port_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned MB = 4;

    logic           wclk = 1'b0;
    logic           wrst_n;
    logic [NR-1:0]  req;
    logic [NR-1:0][DW-1:0] wd;
    logic           full;
    logic           w_en;
    logic [DW-1:0]  wdata;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  ack;
    logic [1:0]     owner;
    logic           stalled;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the port, how many words written, whether blocked.
    int m_owner   = -1;
    int m_writes  = 0;
    bit m_blocked = 1'b0;
    int m_next    = 0;
    logic [NR-1:0] last_ack;

    wr_port_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .wdata_in (wd),
        .full     (full),
        .w_en     (w_en),
        .wdata    (wdata),
        .gnt      (gnt),
        .ack      (ack),
        .owner    (owner),
        .stalled  (stalled)
    );

    always #5 wclk = ~wclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (!wrst_n) begin
            m_owner = -1; m_next = 0; m_writes = 0; m_blocked = 1'b0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (m_next + k) % NR;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c; m_writes = 0; m_blocked = 1'b0;
                end
            end
        end else begin
            bit done;
            done = 1'b0;
            if (!req[m_owner])       done = 1'b1;
            else if (m_blocked)      m_blocked = full;
            else if (full)           m_blocked = 1'b1;
            else begin
                m_writes++;
                if (m_writes == MB) done = 1'b1;
            end
            if (done) begin
                m_next  = (m_owner + 1) % NR;
                m_owner = -1;
            end
        end
    endtask

    // Inputs must already be set (after a negedge); compares, then advances one clock.
    task automatic step();
        bit exp_wen;
        logic [NR-1:0] exp_oh;
        #1;
        exp_oh  = (m_owner >= 0) ? (NR'(1) << m_owner) : '0;
        exp_wen = wrst_n && (m_owner >= 0) && !m_blocked && req[m_owner] && !full;
        check_eq("w_en",    32'(w_en),    32'(exp_wen));
        check_eq("ack",     32'(ack),     exp_wen ? 32'(exp_oh) : 32'd0);
        check_eq("gnt",     32'(gnt),     32'(exp_oh));
        check_eq("owner",   32'(owner),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check_eq("stalled", 32'(stalled), 32'((m_owner >= 0) && m_blocked));
        if (exp_wen) check_eq("wdata", 32'(wdata), 32'(wd[m_owner]));
        last_ack = ack;
        @(posedge wclk);
        model_update();
        @(negedge wclk);
    endtask

    initial begin
        wrst_n = 1'b0;
        req    = 4'b1111;
        full   = 1'b0;
        wd     = '0;
        @(posedge wclk);
        @(negedge wclk);

        // Reset held with all requesters asking: nothing granted or written.
        repeat (2) step();
        wrst_n = 1'b1;

        // Round-robin with everybody asking: 4 acks per owner, one arbitration cycle between.
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < NR; i++) wd[i] = DW'($urandom);
            step();
            if (t % 5 == 0) check_eq("rr_idle_ack", 32'(last_ack), 32'd0);
            else            check_eq("rr_ack", 32'(last_ack), 32'(1) << ((t / 5) % NR));
        end

        // Random traffic: sticky requests, toggling full, occasional reset.
        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < NR; i++) begin
                wd[i] = DW'($urandom);
                if (req[i]) begin
                    if ($urandom_range(7, 0) == 0) req[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                end
            end
            if ($urandom_range(3, 0) == 0) full = ~full;
            wrst_n = ($urandom_range(59, 0) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_port_arbiter.md
WR_PORT_ARBITER -- requirements
Module: wr_port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters; fixed at 4 in this release.
REQ-002 Parameter DATA_W, default 8: width of each write word.
REQ-003 Parameter MAX_BURST, default 4: maximum words per grant, legal range 1..8.
REQ-004 wclk  input  1  write-domain clock; all logic on its rising edge.
REQ-005 wrst_n  input  1  reset, synchronous, active-low.
REQ-006 req  input  NUM_REQ  per-requester write request, level, held while data pending.
REQ-007 wdata_in  input  NUM_REQ x DATA_W  per-requester write word, valid while its req is high.
REQ-008 full  input  1  FIFO full flag from the write-pointer block (registered, wclk domain).
REQ-009 w_en  output  1  FIFO write enable, one word per cycle when high.
REQ-010 wdata  output  DATA_W  word muxed from the owning requester.
REQ-011 gnt  output  NUM_REQ  one-hot registered grant; all-zero when no owner.
REQ-012 ack  output  NUM_REQ  one-hot per-cycle accept; ack[i] high means wdata_in[i] was written this cycle.
REQ-013 owner  output  2  index of the current grant holder; 0 when none.
REQ-014 stalled  output  1  high while the owner is blocked by full.

Function
REQ-015 The FSM SHALL have the states IDLE, GRANT and HOLD, held in a registered state variable.
REQ-016 In IDLE with any req bit set, the block SHALL select the first set bit searching upward from rr_ptr modulo NUM_REQ, register gnt/owner, clear burst_cnt and enter GRANT; no write occurs in that cycle (1-cycle arbitration latency).
REQ-017 In IDLE with req all-zero, the block SHALL remain in IDLE with gnt = 0.
REQ-018 w_en SHALL equal (state == GRANT) AND req[owner] AND NOT full, combinationally; wdata = wdata_in[owner]; ack = w_en ? onehot(owner) : 0.
REQ-019 In GRANT, each write SHALL increment burst_cnt; when a write occurs with burst_cnt == MAX_BURST-1, the grant SHALL be released.
REQ-020 In GRANT with req[owner] low, the grant SHALL be released without writing.
REQ-021 In GRANT with req[owner] high and full high, the block SHALL enter HOLD without writing; burst_cnt is retained.
REQ-022 In HOLD, w_en SHALL be 0 and stalled SHALL be 1; when full falls, the block SHALL return to GRANT (write resumes on the following cycle); when req[owner] falls, the grant SHALL be released.
REQ-023 On release (from either state) the block SHALL go to IDLE, clear gnt, and set rr_ptr = owner+1 modulo NUM_REQ, so the releasing requester has lowest priority at the next arbitration.
REQ-024 A simultaneous burst-end write and a rise in full SHALL count as a release (no HOLD).
REQ-025 Requests from non-owners SHALL be ignored until the next IDLE arbitration; at most one ack bit is ever high.
REQ-026 burst_cnt SHALL be $clog2(MAX_BURST)+1 bits wide so that MAX_BURST = 8 does not wrap.

Reset
REQ-027 While wrst_n is low at a wclk edge: state = IDLE, rr_ptr = 0, burst_cnt = 0, gnt = 0, owner = 0; w_en, ack and stalled are therefore 0 in the following cycle.
REQ-028 Reset asserted mid-burst or in HOLD SHALL abort the grant immediately with no further write.

Structure
REQ-029 The state enum (IDLE/GRANT/HOLD) and NUM_REQ/DATA_W defaults SHALL live in shared package fifo_pkg.
REQ-030 The rotating priority search SHALL be a sub-module rr_pick (inputs req and rr_ptr; outputs a one-hot result and a valid flag), purely combinational.

Verification
REQ-031 Reset: wrst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, w_en=0; after release, first grant goes to requester 0.
REQ-032 Round-robin: req=4'b1111 held, full=0, MAX_BURST=4 -> grant order 0,1,2,3,0; each grant gives 4 consecutive acks separated by one idle cycle.
REQ-033 Early drop: requester 2 alone and granted drops req after 2 writes -> exactly 2 acks, IDLE next cycle, rr_ptr=3.
REQ-034 Full stall: requester 1 granted; full=1 after 1 write for 5 cycles -> HOLD, stalled=1, w_en=0; full=0 -> 3 remaining writes, total 4.
REQ-035 Burst-end with full: full rises in the same cycle as the 4th write -> release to IDLE, stalled never asserted.
REQ-036 Reset mid-HOLD: wrst_n=0 while stalled=1 -> next cycle state IDLE, gnt=0, no ack.
